// File: rtl/br_ram_initializer_addr_counter.sv
`default_nettype none
// ============================================================================
// Module   : br_ram_initializer_addr_counter
// Purpose  : Address counter for the RAM initializer. Clears to 0 on request,
//            increments by one when enabled, and flags the terminal count
//            (count == Depth-1). At terminal count an increment returns the
//            counter to 0, so it rests at 0 between sweeps.
// Ports    : clk      - rising-edge clock
//            rst      - synchronous active-low reset
//            clear    - force the count to 0 (wins over incr)
//            incr     - advance the count
//            count    - current address (AddressWidth bits)
//            terminal - high when count == Depth-1
// Revision : 1.0 - initial release
// ============================================================================
module br_ram_initializer_addr_counter #(
  parameter int Depth        = 2,
  parameter int AddressWidth = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    incr,
  output logic [AddressWidth-1:0] count,
  output logic                    terminal
);

  localparam logic [AddressWidth-1:0] c_last = AddressWidth'(Depth - 1);

  logic [AddressWidth-1:0] r_count;

  // An explicit compare against Depth-1 handles depths that are not a power
  // of two; natural wrap of the counter would overrun them.
  assign terminal = (r_count == c_last);
  assign count    = r_count;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (incr) begin
      r_count <= terminal ? '0 : r_count + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/br_ram_initializer.sv
`default_nettype none
// ============================================================================
// Module   : br_ram_initializer
// Purpose  : Fills every entry of an attached RAM with one programmable value.
//            A one-cycle start in IDLE captures initial_value and issues one
//            write per cycle to addresses 0..Depth-1, then returns to IDLE.
// Ports    : clk           - rising-edge clock
//            rst           - synchronous active-low reset
//            initial_value - fill value, sampled when start is accepted
//            start         - request to begin initialization
//            busy          - initialization pending or in progress
//            wr_valid      - RAM write enable
//            wr_addr       - RAM write address
//            wr_data       - RAM write data
// Revision : 1.0 - initial release
// ============================================================================
module br_ram_initializer #(
  parameter  int Depth        = 2,
  parameter  int Width        = 1,
  localparam int AddressWidth = $clog2(Depth)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [Width-1:0]        initial_value,
  input  logic                    start,
  output logic                    busy,
  output logic                    wr_valid,
  output logic [AddressWidth-1:0] wr_addr,
  output logic [Width-1:0]        wr_data
);

  generate
    if (Depth < 2) begin : g_bad_depth
      $error("br_ram_initializer: Depth must be at least 2");
    end
    if (Width < 1) begin : g_bad_width
      $error("br_ram_initializer: Width must be at least 1");
    end
  endgenerate

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;

  state_t                  r_state;
  state_t                  w_next_state;
  logic                    w_accept;
  logic                    w_last;
  logic [Width-1:0]        r_data;
  logic [AddressWidth-1:0] w_count;

  br_ram_initializer_addr_counter #(
    .Depth        (Depth),
    .AddressWidth (AddressWidth)
  ) u_addr_counter (
    .clk      (clk),
    .rst      (rst),
    .clear    (w_accept),
    .incr     (r_state == WRITE),
    .count    (w_count),
    .terminal (w_last)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_accept     = 1'b1;
          w_next_state = WRITE;
        end
      end
      WRITE: begin
        if (w_last) begin
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // The data register is zeroed on the last write so wr_data reads 0 in IDLE
  // straight from a flop, with no output gating.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_data <= '0;
    end else if (w_accept) begin
      r_data <= initial_value;
    end else if ((r_state == WRITE) && w_last) begin
      r_data <= '0;
    end
  end

  // busy rises combinationally in the request cycle so neighbours stall at once.
  assign busy     = (r_state == WRITE) || ((r_state == IDLE) && start);
  assign wr_valid = (r_state == WRITE);
  assign wr_addr  = w_count;
  assign wr_data  = r_data;

  a_no_x_outputs : assert property (@(posedge clk) disable iff (!rst)
    !$isunknown({busy, wr_valid, wr_addr, wr_data}));

  a_addr_in_range : assert property (@(posedge clk) disable iff (!rst)
    wr_valid |-> (32'(wr_addr) < 32'(Depth)));

  a_valid_implies_busy : assert property (@(posedge clk) disable iff (!rst)
    wr_valid |-> busy);

endmodule
`default_nettype wire

// File: tb/tb_br_ram_initializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_br_ram_initializer
// Purpose  : Directed self-checking bench for br_ram_initializer. Four
//            instances with different Depth/Width share one clock; each
//            scenario drives one instance. Inputs change on the falling edge
//            and outputs are compared 1 ns later.
// Revision : 1.0 - initial release
// ============================================================================
module tb_br_ram_initializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic fall;
    @(negedge clk);
  endtask

  // ---------------- instance A: Depth=2, Width=1 ----------------
  logic       rst_a = 1'b0, start_a = 1'b0, busy_a, wv_a;
  logic [0:0] iv_a = '0, wa_a, wd_a;
  br_ram_initializer #(.Depth(2), .Width(1)) u_a (
    .clk(clk), .rst(rst_a), .initial_value(iv_a), .start(start_a),
    .busy(busy_a), .wr_valid(wv_a), .wr_addr(wa_a), .wr_data(wd_a));

  // ---------------- instance B: Depth=5, Width=8 ----------------
  logic       rst_b = 1'b0, start_b = 1'b0, busy_b, wv_b;
  logic [7:0] iv_b = '0, wd_b;
  logic [2:0] wa_b;
  br_ram_initializer #(.Depth(5), .Width(8)) u_b (
    .clk(clk), .rst(rst_b), .initial_value(iv_b), .start(start_b),
    .busy(busy_b), .wr_valid(wv_b), .wr_addr(wa_b), .wr_data(wd_b));

  // ---------------- instance C: Depth=4, Width=8 ----------------
  logic       rst_c = 1'b0, start_c = 1'b0, busy_c, wv_c;
  logic [7:0] iv_c = '0, wd_c;
  logic [1:0] wa_c;
  br_ram_initializer #(.Depth(4), .Width(8)) u_c (
    .clk(clk), .rst(rst_c), .initial_value(iv_c), .start(start_c),
    .busy(busy_c), .wr_valid(wv_c), .wr_addr(wa_c), .wr_data(wd_c));

  // ---------------- instance D: Depth=8, Width=8 ----------------
  logic       rst_d = 1'b0, start_d = 1'b0, busy_d, wv_d;
  logic [7:0] iv_d = '0, wd_d;
  logic [2:0] wa_d;
  br_ram_initializer #(.Depth(8), .Width(8)) u_d (
    .clk(clk), .rst(rst_d), .initial_value(iv_d), .start(start_d),
    .busy(busy_d), .wr_valid(wv_d), .wr_addr(wa_d), .wr_data(wd_d));

  initial begin
    // ---- reset, Depth=2: three cycles low with start=0 ----
    repeat (3) fall();
    #1;
    check("a_rst_busy",  32'(busy_a), 32'd0);
    check("a_rst_valid", 32'(wv_a),   32'd0);
    check("a_rst_addr",  32'(wa_a),   32'd0);
    check("a_rst_data",  32'(wd_a),   32'd0);
    check("d_rst_valid", 32'(wv_d),   32'd0);
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1; rst_d = 1'b1;

    // ---- basic fill, Depth=2, value 1 ----
    fall(); start_a = 1'b1; iv_a = 1'b1; #1;
    check("a_req_busy",  32'(busy_a), 32'd1);
    check("a_req_valid", 32'(wv_a),   32'd0);
    for (int k = 0; k < 2; k++) begin
      fall(); start_a = 1'b0; iv_a = 1'b0; #1;
      check("a_wr_valid", 32'(wv_a),   32'd1);
      check("a_wr_addr",  32'(wa_a),   32'(k));
      check("a_wr_data",  32'(wd_a),   32'd1);
      check("a_wr_busy",  32'(busy_a), 32'd1);
    end
    fall(); #1;
    check("a_end_busy",  32'(busy_a), 32'd0);
    check("a_end_valid", 32'(wv_a),   32'd0);
    check("a_end_addr",  32'(wa_a),   32'd0);

    // ---- non-power-of-2, Depth=5, 0xA5, then back-to-back with 0x00 ----
    fall(); start_b = 1'b1; iv_b = 8'hA5; #1;
    check("b_req_busy", 32'(busy_b), 32'd1);
    for (int k = 0; k < 5; k++) begin
      fall(); start_b = 1'b0; iv_b = 8'hFF; #1;
      check("b_wr_valid", 32'(wv_b), 32'd1);
      check("b_wr_addr",  32'(wa_b), 32'(k));
      check("b_wr_data",  32'(wd_b), 32'hA5);
    end
    fall(); #1;
    check("b_idle_valid", 32'(wv_b),   32'd0);
    check("b_idle_busy",  32'(busy_b), 32'd0);
    check("b_idle_data",  32'(wd_b),   32'd0);
    start_b = 1'b1; iv_b = 8'h00; #1;
    check("b_b2b_busy", 32'(busy_b), 32'd1);
    for (int k = 0; k < 5; k++) begin
      fall(); start_b = 1'b0; iv_b = 8'h99; #1;
      check("b2_wr_valid", 32'(wv_b), 32'd1);
      check("b2_wr_addr",  32'(wa_b), 32'(k));
      check("b2_wr_data",  32'(wd_b), 32'h00);
    end
    fall(); #1;
    check("b2_end_valid", 32'(wv_b),   32'd0);
    check("b2_end_busy",  32'(busy_b), 32'd0);

    // ---- start ignored while busy, Depth=4 ----
    fall(); start_c = 1'b1; iv_c = 8'h5A; #1;
    check("c_req_busy", 32'(busy_c), 32'd1);
    for (int k = 0; k < 4; k++) begin
      fall();
      start_c = (k == 1);
      if (k == 1) iv_c = 8'h3C;
      #1;
      check("c_wr_valid", 32'(wv_c),   32'd1);
      check("c_wr_addr",  32'(wa_c),   32'(k));
      check("c_wr_data",  32'(wd_c),   32'h5A);
      check("c_wr_busy",  32'(busy_c), 32'd1);
    end
    fall(); start_c = 1'b0; #1;
    check("c_end_busy",  32'(busy_c), 32'd0);
    check("c_end_valid", 32'(wv_c),   32'd0);
    fall(); #1;
    check("c_norestart_valid", 32'(wv_c), 32'd0);

    // ---- reset mid-sequence, Depth=8 ----
    fall(); start_d = 1'b1; iv_d = 8'h77; #1;
    for (int k = 0; k < 4; k++) begin
      fall(); start_d = 1'b0; #1;
      check("d_wr_addr", 32'(wa_d), 32'(k));
      check("d_wr_data", 32'(wd_d), 32'h77);
    end
    rst_d = 1'b0;
    fall(); rst_d = 1'b1; #1;
    check("d_abort_valid", 32'(wv_d),   32'd0);
    check("d_abort_busy",  32'(busy_d), 32'd0);
    check("d_abort_addr",  32'(wa_d),   32'd0);
    check("d_abort_data",  32'(wd_d),   32'd0);
    for (int k = 0; k < 3; k++) begin
      fall(); #1;
      check("d_after_valid", 32'(wv_d), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
